alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_rr_arb2.sv | 36 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcode map, legal-opcode
// bound and FSM state encoding.
package alu_arbiter_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_COMP = 1;
    localparam int OP_AND  = 2;
    localparam int OP_XOR  = 3;
    localparam int OP_SHLL = 4;
    localparam int OP_SHRL = 5;
    localparam int OP_SHRA = 6;
    localparam int OP_DIFF = 7;
    localparam int OP_ZERO = 8;

    // Highest opcode the ALU implements; anything above is answered with err.
    localparam int OP_MAX  = 8;
    // Opcode that makes the external ALU output 0 while no operation is issued.
    localparam int OP_IDLE = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter with a one-bit priority pointer. Round-robin by default;
// with ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic prio;
    logic tie_pick;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    assign tie_pick = prio;
`endif

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = tie_pick ? 2'b10 : 2'b01;
        end
    end

    // Favour the requester that was not just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= 1'b0;
        end else if (take) begin
            prio <= ~gnt[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Build option: ALU_ARB_FIXED_PRIO_EN selects strict requester-0 priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_sign,
    output logic              rsp_err,
    output logic              busy
);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          gnt;
    logic                accept;
    logic                sel_id;
    logic                sel_legal;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_valid),
        .take (accept),
        .gnt  (gnt)
    );

    assign sel_id    = gnt[1];
    assign sel_op    = sel_id ? req_op1 : req_op0;
    assign sel_a     = sel_id ? req_a1  : req_a0;
    assign sel_b     = sel_id ? req_b1  : req_b0;
    assign sel_legal = (sel_op <= OP_W'(OP_MAX));

    assign accept    = (state == ST_IDLE) && (gnt != 2'b00);
    assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = sel_legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand registers are only observed during ISSUE, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= sel_op;
            a_q  <= sel_a;
            b_q  <= sel_b;
        end
    end

    // Response registers stay untouched through RESP, keeping rsp_* stable
    // under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_sign <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_id <= sel_id;
            if (!sel_legal) begin
                rsp_data <= '0;
                rsp_zero <= 1'b0;
                rsp_sign <= 1'b0;
                rsp_err  <= 1'b1;
            end
        end else if (state == ST_ISSUE) begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
            rsp_sign <= alu_sign;
            rsp_err  <= 1'b0;
        end
    end

    always_comb begin
        alu_op  = OP_W'(OP_IDLE);
        alu_in1 = '0;
        alu_in2 = '0;
        if (state == ST_ISSUE) begin
            alu_op  = op_q;
            alu_in1 = a_q;
            alu_in2 = b_q;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner cases and
// a randomized run against a transaction-level model of the arbiter.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_zero, alu_sign;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_sign, rsp_err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external ALU.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: alu_f = a + b;
            4'd1: alu_f = ~a;
            4'd2: alu_f = a & b;
            4'd3: alu_f = a ^ b;
            4'd4: alu_f = a << b[4:0];
            4'd5: alu_f = a >> b[4:0];
            4'd6: alu_f = 32'($signed(a) >>> b[4:0]);
            4'd7: alu_f = a - b;
            4'd8: alu_f = a;
            default: alu_f = 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_f(alu_op, alu_in1, alu_in2);
        alu_zero = (alu_out == 32'd0);
        alu_sign = alu_out[31];
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk32({tag, " req_ready"}, 32'(req_ready), 32'd0);
        chk1({tag, " rsp_valid"}, rsp_valid, 1'b0);
        chk1({tag, " rsp_id"}, rsp_id, 1'b0);
        chk32({tag, " rsp_data"}, rsp_data, 32'd0);
        chk1({tag, " rsp_zero"}, rsp_zero, 1'b0);
        chk1({tag, " rsp_sign"}, rsp_sign, 1'b0);
        chk1({tag, " rsp_err"}, rsp_err, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk32({tag, " alu_op"}, 32'(alu_op), 32'd15);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        #2;
        chk_cleared("reset");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
    endtask

    // Offers one request right after an edge and counts edges until rsp_valid.
    task automatic run_op(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic rid, output logic [31:0] d, output logic z, output logic s,
                          output logic e, output int lat);
        @(posedge clk); #1;
        set_req(id, op, a, b);
        req_valid = (id == 0) ? 2'b01 : 2'b10;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rid = rsp_id; d = rsp_data; z = rsp_zero; s = rsp_sign; e = rsp_err;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        z;
        logic        s;
        logic        e;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rid, z, s, e;
        logic [31:0] d;
        int          lat;
        int          ids[4];
        int          nid;
        int          cyc;
        // model state for the random run
        logic        idle_m, last_m, win;
        int          wait_m;
        logic [1:0]  exp_rdy;
        logic        m_id, m_err;
        logic [3:0]  m_op;
        logic [31:0] m_a, m_b, m_d;

        tbl[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'd3,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'd7,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{4'd2,  32'hF0F0_0000, 32'hFF00_FF00, 32'hF000_0000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{4'd4,  32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'd6,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'd5,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'd1,  32'hFFFF_FFFF, 32'd0,         32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'd8,  32'h0000_0000, 32'd123,       32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{4'd9,  32'h0000_1234, 32'd1,         32'h0000_0000, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        set_req(0, 4'd0, 32'd0, 32'd0);
        set_req(1, 4'd0, 32'd0, 32'd0);
        #3;
        chk_cleared("por");
        @(posedge clk); #1;
        rst = 1'b1;

        // Vector table: alternate requesters, check payload and latency.
        for (int i = 0; i < 11; i++) begin
            run_op(i % 2, tbl[i].op, tbl[i].a, tbl[i].b, rid, d, z, s, e, lat);
            chk32($sformatf("vec%0d latency", i), 32'(lat), tbl[i].e ? 32'd1 : 32'd2);
            chk1($sformatf("vec%0d rsp_id", i), rid, 1'(i % 2));
            chk32($sformatf("vec%0d rsp_data", i), d, tbl[i].d);
            chk1($sformatf("vec%0d rsp_zero", i), z, tbl[i].z);
            chk1($sformatf("vec%0d rsp_sign", i), s, tbl[i].s);
            chk1($sformatf("vec%0d rsp_err", i), e, tbl[i].e);
        end
        drain();

        // Tie fairness: both held valid for four operations.
        do_reset();
        set_req(0, 4'd0, 32'd1, 32'd2);
        set_req(1, 4'd0, 32'd3, 32'd4);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        nid = 0;
        cyc = 0;
        while (nid < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid) begin
                ids[nid] = int'(rsp_id);
                nid++;
            end
        end
        req_valid = 2'b00;
        chk32("tie count", 32'(nid), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk32($sformatf("tie grant%0d", i), 32'(ids[i]), 32'd0);
`else
            chk32($sformatf("tie grant%0d", i), 32'(ids[i]), 32'(i % 2));
`endif
        end
        drain();

        // Backpressure: response must hold while rsp_ready is low.
        @(posedge clk); #1;
        set_req(1, 4'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b11;
        cyc = 0;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            chk1($sformatf("bp%0d rsp_valid", k), rsp_valid, 1'b1);
            chk1($sformatf("bp%0d rsp_id", k), rsp_id, 1'b1);
            chk32($sformatf("bp%0d rsp_data", k), rsp_data, 32'd0);
            chk1($sformatf("bp%0d rsp_zero", k), rsp_zero, 1'b1);
            chk32($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk1("bp release rsp_valid", rsp_valid, 1'b0);
        chk1("bp release busy", busy, 1'b0);

        // Illegal opcode: no ALU issue, error response one edge after accept.
        set_req(0, 4'd9, 32'hDEAD_BEEF, 32'h1);
        req_valid = 2'b01;
        #1;
        chk32("ill offer alu_op", 32'(alu_op), 32'd15);
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk1("ill rsp_valid", rsp_valid, 1'b1);
        chk1("ill rsp_err", rsp_err, 1'b1);
        chk32("ill rsp_data", rsp_data, 32'd0);
        chk32("ill alu_op", 32'(alu_op), 32'd15);
        chk32("ill alu_in1", alu_in1, 32'd0);
        drain();

        // Reset in the middle of an operation owned by requester 1.
        do_reset();
        run_op(0, 4'd0, 32'd1, 32'd1, rid, d, z, s, e, lat);
        @(posedge clk); #1;
        set_req(1, 4'd0, 32'hFFFF_FFFF, 32'd1);
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk1("mid busy", busy, 1'b1);
        chk32("mid alu_op", 32'(alu_op), 32'd0);
        chk32("mid alu_in1", alu_in1, 32'hFFFF_FFFF);
        rst = 1'b0;
        #1;
        chk_cleared("mid-reset");
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk1($sformatf("post-reset%0d rsp_valid", k), rsp_valid, 1'b0);
        end
        req_valid = 2'b11;
        #1;
        chk32("post-reset tie", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        drain();

        // Randomized run against the transaction-level model.
        do_reset();
        idle_m = 1'b1;
        last_m = 1'b1;
        wait_m = 0;
        m_id = 1'b0; m_err = 1'b0; m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_d = 32'd0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 3) != 0);
            set_req(0, ($urandom_range(0, 15) == 0) ? 4'd12 : 4'($urandom_range(0, 8)), $urandom, $urandom);
            set_req(1, ($urandom_range(0, 15) == 0) ? 4'd10 : 4'($urandom_range(0, 8)), $urandom, $urandom);
            @(negedge clk);
            exp_rdy = 2'b00;
            win = 1'b0;
            if (idle_m && req_valid != 2'b00) begin
                if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    win = 1'b0;
`else
                    win = ~last_m;
`endif
                end else begin
                    win = req_valid[1];
                end
                exp_rdy = win ? 2'b10 : 2'b01;
            end
            chk32("rnd req_ready", 32'(req_ready), 32'(exp_rdy));
            chk1("rnd busy", busy, !idle_m);
            chk1("rnd rsp_valid", rsp_valid, !idle_m && wait_m == 0);
            if (!idle_m && wait_m == 0) begin
                chk1("rnd rsp_id", rsp_id, m_id);
                chk1("rnd rsp_err", rsp_err, m_err);
                chk32("rnd rsp_data", rsp_data, m_d);
                chk1("rnd rsp_zero", rsp_zero, !m_err && m_d == 32'd0);
                chk1("rnd rsp_sign", rsp_sign, m_d[31]);
            end
            if (!idle_m && wait_m == 1) begin
                chk32("rnd alu_op", 32'(alu_op), 32'(m_op));
                chk32("rnd alu_in1", alu_in1, m_a);
                chk32("rnd alu_in2", alu_in2, m_b);
            end else begin
                chk32("rnd alu_op idle", 32'(alu_op), 32'd15);
            end
            // advance the model across the coming edge
            if (idle_m) begin
                if (req_valid != 2'b00) begin
                    idle_m = 1'b0;
                    last_m = win;
                    m_id   = win;
                    m_op   = win ? req_op1 : req_op0;
                    m_a    = win ? req_a1 : req_a0;
                    m_b    = win ? req_b1 : req_b0;
                    m_err  = (m_op > 4'd8);
                    m_d    = m_err ? 32'd0 : alu_f(m_op, m_a, m_b);
                    wait_m = m_err ? 0 : 1;
                end
            end else if (wait_m > 0) begin
                wait_m--;
            end else if (rsp_ready) begin
                idle_m = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
